mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-port synchronous RAM between the twitchcore instruction-fetch port and its load/store port, so that code and data live in one unified memory. Round-robin arbitration with valid/ready request handshakes and a fixed one-cycle response. It sits between the core's memory ports and the RAM macro, and accepts at most one access per cycle.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 70 +++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the RAM macro.
// The arbiter takes the slave view; the core/RAM side takes the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              i_valid;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_valid;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [STRB_W-1:0] d_wstrb;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [STRB_W-1:0] mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_valid, i_addr, d_valid, d_addr, d_we, d_wstrb, d_wdata, mem_rdata,
        output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output i_valid, i_addr, d_valid, d_addr, d_we, d_wstrb, d_wdata, mem_rdata,
        input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between instruction
// fetch and load/store; one access per cycle, fixed one-cycle response.
module mem_arbiter (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus
);
    logic rr_q, rr_d;
    logic rsp_i_q, rsp_i_d;
    logic rsp_d_q, rsp_d_d;
    logic rsp_w_q, rsp_w_d;
    logic grant_i, grant_d;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        rr_d    = rr_q;
        rsp_i_d = 1'b0;
        rsp_d_d = 1'b0;
        rsp_w_d = 1'b0;

        // rr = 1 hands a tie to fetch; a lone requester always wins.
        if (resetn) begin
            grant_i = bus.i_valid && (!bus.d_valid || rr_q);
            grant_d = bus.d_valid && (!bus.i_valid || !rr_q);
        end

        if (grant_i) begin
            rr_d = 1'b0;
        end else if (grant_d) begin
            rr_d = 1'b1;
        end

        rsp_i_d = grant_i;
        rsp_d_d = grant_d;
        rsp_w_d = grant_d && bus.d_we;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_q    <= 1'b0;
            rsp_i_q <= 1'b0;
            rsp_d_q <= 1'b0;
            rsp_w_q <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            rsp_i_q <= rsp_i_d;
            rsp_d_q <= rsp_d_d;
            rsp_w_q <= rsp_w_d;
        end
    end

    always_comb begin
        bus.i_ready   = grant_i;
        bus.d_ready   = grant_d;
        bus.mem_en    = grant_i || grant_d;
        bus.mem_addr  = grant_d ? bus.d_addr : bus.i_addr;
        bus.mem_we    = (grant_d && bus.d_we) ? bus.d_wstrb : '0;
        bus.mem_wdata = bus.d_wdata;
    end

    // Responses are masked while resetn is low so a grant just before a reset
    // never surfaces; d_rdata is held at zero unless a read response is showing.
    always_comb begin
        bus.i_rvalid = rsp_i_q && resetn;
        bus.i_rdata  = bus.mem_rdata;
        bus.d_rvalid = rsp_d_q && resetn;
        bus.d_rdata  = (rsp_d_q && !rsp_w_q) ? bus.mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_mem_arbiter;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic resetn;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void chkv(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] init_word(int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    // RAM macro: single port, registered read, byte write enables.
    logic [DW-1:0] ram [0:DEPTH-1];
    bit ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= init_word(k);
            ram_ready <= 1'b1;
        end else if (bus.mem_en) begin
            for (int b = 0; b < SW; b++)
                if (bus.mem_we[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Behavioural model: a lone requester wins; on a tie the port that did not win
    // the most recent grant wins (data first out of reset). Every grant yields one
    // response on the next cycle carrying the memory word as of the grant.
    logic [DW-1:0] shadow [0:DEPTH-1];
    bit            shadow_ready = 1'b0;
    bit            model_on     = 1'b0;
    bit            last_win_d   = 1'b0;
    bit            exp_iv = 1'b0, exp_dv = 1'b0;
    logic [DW-1:0] exp_id, exp_dd;

    always @(negedge clk) begin : model
        bit gi, gd;
        if (!shadow_ready) begin
            for (int k = 0; k < DEPTH; k++) shadow[k] = init_word(k);
            shadow_ready = 1'b1;
        end
        gi = resetn && bus.i_valid && (!bus.d_valid || last_win_d);
        gd = resetn && bus.d_valid && (!bus.i_valid || !last_win_d);

        if (model_on) begin
            chk1("m_i_rvalid", bus.i_rvalid, exp_iv && resetn);
            chk1("m_d_rvalid", bus.d_rvalid, exp_dv && resetn);
            if (exp_iv && resetn) chkv("m_i_rdata", bus.i_rdata, exp_id);
            if (exp_dv && resetn) chkv("m_d_rdata", bus.d_rdata, exp_dd);
            chk1("m_i_ready", bus.i_ready, gi);
            chk1("m_d_ready", bus.d_ready, gd);
            chk1("m_mem_en", bus.mem_en, gi || gd);
            chkv("m_mem_we", 32'(bus.mem_we), (gd && bus.d_we) ? 32'(bus.d_wstrb) : 32'd0);
            if (gi || gd) chkv("m_mem_addr", 32'(bus.mem_addr), gd ? 32'(bus.d_addr) : 32'(bus.i_addr));
            if (gd && bus.d_we) chkv("m_mem_wdata", bus.mem_wdata, bus.d_wdata);
        end

        if (!resetn) begin
            model_on   = 1'b1;
            last_win_d = 1'b0;
            exp_iv     = 1'b0;
            exp_dv     = 1'b0;
        end else begin
            exp_iv = gi;
            exp_id = shadow[bus.i_addr];
            exp_dv = gd;
            exp_dd = bus.d_we ? '0 : shadow[bus.d_addr];
            if (gd && bus.d_we)
                for (int b = 0; b < SW; b++)
                    if (bus.d_wstrb[b]) shadow[bus.d_addr][b*8 +: 8] = bus.d_wdata[b*8 +: 8];
            if (gd) last_win_d = 1'b1;
            else if (gi) last_win_d = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_valid = 1'b0; bus.i_addr = '0;
        bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_we = 1'b0;
        bus.d_wstrb = '0;   bus.d_wdata = '0;
    endtask

    // One data-port transaction with the fetch port idle; checks accept and response.
    task automatic d_txn(string name, logic we, logic [AW-1:0] addr, logic [SW-1:0] strb,
                         logic [DW-1:0] data, logic [DW-1:0] exp_rdata);
        step();
        bus.d_valid = 1'b1; bus.d_we = we; bus.d_addr = addr;
        bus.d_wstrb = strb; bus.d_wdata = data;
        mid();
        chk1({name, "_ready"}, bus.d_ready, 1'b1);
        step();
        bus.d_valid = 1'b0;
        mid();
        chk1({name, "_rvalid"}, bus.d_rvalid, 1'b1);
        chkv({name, "_rdata"}, bus.d_rdata, exp_rdata);
        $display("txn %s: we=%0b addr=%h strb=%b wdata=%h -> rdata=%h", name, we, addr, strb, data, bus.d_rdata);
    endtask

    task automatic do_reset(int cycles);
        step();
        resetn = 1'b0;
        repeat (cycles) step();
        resetn = 1'b1;
    endtask

    logic i_acc, d_acc;

    initial begin
        resetn = 1'b0;
        idle_inputs();
        bus.mem_rdata = '0;
        // Requests held during reset must not be granted or reach the RAM.
        bus.i_valid = 1'b1; bus.d_valid = 1'b1; bus.d_we = 1'b1;
        bus.d_wstrb = 4'hF; bus.d_wdata = 32'hBAD0_BAD0; bus.d_addr = 12'h010;
        repeat (3) begin
            step();
            mid();
            chk1("rst_i_ready", bus.i_ready, 1'b0);
            chk1("rst_d_ready", bus.d_ready, 1'b0);
            chk1("rst_mem_en", bus.mem_en, 1'b0);
            chkv("rst_mem_we", 32'(bus.mem_we), 32'd0);
        end
        step();
        resetn = 1'b1;
        idle_inputs();
        mid();
        chk1("post_rst_i_rvalid", bus.i_rvalid, 1'b0);
        chk1("post_rst_d_rvalid", bus.d_rvalid, 1'b0);
        chkv("post_rst_d_rdata", bus.d_rdata, 32'd0);
        repeat (3) begin
            step();
            mid();
            chk1("idle_mem_en", bus.mem_en, 1'b0);
            chk1("idle_i_rvalid", bus.i_rvalid, 1'b0);
            chk1("idle_d_rvalid", bus.d_rvalid, 1'b0);
        end

        // Write then immediate read of the same word.
        step();
        bus.d_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h010;
        bus.d_wstrb = 4'hF; bus.d_wdata = 32'hDEAD_BEEF;
        mid();
        chk1("wr_ready", bus.d_ready, 1'b1);
        chkv("wr_mem_we", 32'(bus.mem_we), 32'hF);
        chkv("wr_mem_addr", 32'(bus.mem_addr), 32'h010);
        step();
        bus.d_we = 1'b0;
        mid();
        chk1("wr_ack_rvalid", bus.d_rvalid, 1'b1);
        chkv("wr_ack_rdata", bus.d_rdata, 32'd0);
        chk1("rd_ready", bus.d_ready, 1'b1);
        step();
        bus.d_valid = 1'b0;
        mid();
        chk1("raw_rvalid", bus.d_rvalid, 1'b1);
        chkv("raw_rdata", bus.d_rdata, 32'hDEAD_BEEF);

        // Byte strobes, including an all-zero strobe write.
        d_txn("w_full",  1'b1, 12'h020, 4'hF, 32'h1122_3344, 32'd0);
        d_txn("w_byte1", 1'b1, 12'h020, 4'b0010, 32'h0000_AA00, 32'd0);
        d_txn("r_merge", 1'b0, 12'h020, 4'h0, 32'd0, 32'h1122_AA44);
        d_txn("w_nostrb", 1'b1, 12'h020, 4'h0, 32'hFFFF_FFFF, 32'd0);
        d_txn("r_keep",  1'b0, 12'h020, 4'h0, 32'd0, 32'h1122_AA44);

        // Continuous contention right after reset alternates D,I,D,I,D,I.
        do_reset(2);
        idle_inputs();
        step();
        bus.i_valid = 1'b1; bus.i_addr = 12'h031;
        bus.d_valid = 1'b1; bus.d_addr = 12'h030; bus.d_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mid();
            chk1("alt_d_ready", bus.d_ready, (k % 2) == 0);
            chk1("alt_i_ready", bus.i_ready, (k % 2) == 1);
            if (k > 0 && (k % 2) == 0) chkv("alt_i_rdata", bus.i_rdata, init_word('h031));
            step();
        end
        bus.i_valid = 1'b0; bus.d_valid = 1'b0;

        // Fetch-only burst; then a tie must go to the data port.
        for (int k = 0; k < 4; k++) begin
            bus.i_valid = 1'b1; bus.i_addr = AW'(k);
            mid();
            chk1("burst_i_ready", bus.i_ready, 1'b1);
            if (k > 0) chkv("burst_i_rdata", bus.i_rdata, init_word(k - 1));
            step();
        end
        bus.i_valid = 1'b1; bus.i_addr = 12'h007;
        bus.d_valid = 1'b1; bus.d_addr = 12'h008; bus.d_we = 1'b0;
        mid();
        chk1("burst_last_rvalid", bus.i_rvalid, 1'b1);
        chkv("burst_last_rdata", bus.i_rdata, init_word(3));
        chk1("after_burst_d_ready", bus.d_ready, 1'b1);
        chk1("after_burst_i_ready", bus.i_ready, 1'b0);
        step();
        bus.d_valid = 1'b0;
        mid();
        chk1("after_burst_i_grant", bus.i_ready, 1'b1);
        step();
        bus.i_valid = 1'b0;

        // A fetch granted right before a reset edge never responds.
        step();
        bus.i_valid = 1'b1; bus.i_addr = 12'h005;
        mid();
        chk1("pre_rst_i_ready", bus.i_ready, 1'b1);
        step();
        bus.i_valid = 1'b0;
        resetn = 1'b0;
        mid();
        chk1("drop_i_rvalid_a", bus.i_rvalid, 1'b0);
        step();
        resetn = 1'b1;
        mid();
        chk1("drop_i_rvalid_b", bus.i_rvalid, 1'b0);
        step();
        bus.i_valid = 1'b1; bus.i_addr = 12'h006;
        bus.d_valid = 1'b1; bus.d_addr = 12'h009; bus.d_we = 1'b0;
        mid();
        chk1("rr_after_rst_d", bus.d_ready, 1'b1);
        chk1("rr_after_rst_i", bus.i_ready, 1'b0);
        step();
        bus.d_valid = 1'b0;
        step();
        bus.i_valid = 1'b0;

        // Random traffic; each requester holds its request until it is accepted.
        mid();
        for (int c = 0; c < 3000; c++) begin
            i_acc = bus.i_ready;
            d_acc = bus.d_ready;
            step();
            resetn = ($urandom_range(0, 249) != 0);
            if (!bus.i_valid || i_acc) begin
                bus.i_valid = ($urandom_range(0, 3) != 0);
                bus.i_addr  = AW'($urandom_range(0, 31));
            end
            if (!bus.d_valid || d_acc) begin
                bus.d_valid = ($urandom_range(0, 3) != 0);
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = AW'($urandom_range(0, 31));
                bus.d_wstrb = SW'($urandom);
                bus.d_wdata = $urandom;
            end
            mid();
        end
        step();
        resetn = 1'b1;
        idle_inputs();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
